// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx writeback path: widths, load funct3 codes
// and the commit-queue entry layout.
package ysyx_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   pc;
    logic              is_load;
    logic [2:0]        ld_type;
    logic [1:0]        ld_off;
    logic              filled;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_load_extend.sv
// Combinational load data alignment: picks the byte/halfword addressed by the
// load offset and sign- or zero-extends it according to funct3.
module ysyx_load_extend
  import ysyx_pkg::*;
(
  input  logic [2:0]      ld_type,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_type)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LW:   result = rdata;
      LD_LBU:  result = {24'd0, byte_sel};
      LD_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_writeback.sv
// In-order commit queue feeding the register-file write port; loads wait in
// their slot until the memory response fills them, then retire in order.
module ysyx_writeback
  import ysyx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_data,
  input  logic              in_is_load,
  input  logic [2:0]        in_ld_type,
  input  logic [1:0]        in_ld_off,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              mem_rready,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic [XLEN-1:0]   pending,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on the same-cycle valid or data.
  wb_entry_t        q [DEPTH];
  logic [PTR_W-1:0] head, tail, ld_ptr;
  logic [PTR_W:0]   count;
  logic             ld_found;
  logic             push, pop, fill;
  logic [XLEN-1:0]  ext_data;
  wb_entry_t        head_e;

  assign in_ready   = (count < (PTR_W + 1)'(DEPTH));
  assign empty      = (count == '0);
  assign mem_rready = ld_found;
  assign push       = in_valid && in_ready;
  assign fill       = mem_rvalid && ld_found;
  assign head_e     = q[head];
  assign pop        = head_e.valid && head_e.filled;

  // Loads are filled in order, so the oldest unfilled load is the first one
  // found walking from head.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    ld_ptr   = head;
    ld_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (!ld_found && q[idx].valid && q[idx].is_load && !q[idx].filled) begin
        ld_found = 1'b1;
        ld_ptr   = idx;
      end
    end
  end

  ysyx_load_extend u_load_extend (
    .ld_type (q[ld_ptr].ld_type),
    .ld_off  (q[ld_ptr].ld_off),
    .rdata   (mem_rdata),
    .result  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      if (push) begin
        q[tail] <= '{valid:   1'b1,
                     rd:      in_rd,
                     data:    in_is_load ? '0 : in_data,
                     pc:      in_pc,
                     is_load: in_is_load,
                     ld_type: in_ld_type,
                     ld_off:  in_ld_off,
                     filled:  !in_is_load};
        tail <= tail + 1'b1;
      end
      if (fill) begin
        q[ld_ptr].data   <= ext_data;
        q[ld_ptr].filled <= 1'b1;
      end
      if (pop) begin
        q[head].valid <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    commit_valid = pop;
    rf_wr_en     = pop && (head_e.rd != '0);
    rf_waddr     = pop ? head_e.rd : '0;
    rf_wdata     = pop ? head_e.data : '0;
    commit_pc    = pop ? head_e.pc : '0;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid) pending[q[i].rd] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule

// File: doc/ysyx_writeback.md
# ysyx_writeback

In-order writeback unit that drives the integer register file write port (`rf_wr_en`/`waddr`/`wdata`) for the ysyx single-issue core. It accepts retiring instructions from EXU into a small commit queue. It merges load data returned by the memory side and sign- or zero-extends it per load type. It commits at most one register write per cycle in program order, and exports a pending-destination bitmap for hazard detection.

## Interface
Parameters:
- `DEPTH`, 4: commit-queue entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: EXU presents a retiring instruction.
- `in_ready` output 1: queue can accept; equals `count < DEPTH`, no combinational dependence on inputs.
- `in_rd` input 5: destination register.
- `in_data` input 32: ALU result; ignored when `in_is_load`.
- `in_is_load` input 1: result comes from a later memory response.
- `in_ld_type` input 3: load funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- `in_ld_off` input 2: address bits [1:0] of the load.
- `in_pc` input 32: instruction PC, carried to commit.
- `mem_rvalid` input 1: load response valid.
- `mem_rdata` input 32: raw aligned word.
- `mem_rready` output 1: high iff at least one queued load entry is still unfilled.
- `rf_wr_en` output 1: register-file write strobe.
- `rf_waddr` output 5: write address.
- `rf_wdata` output 32: write data.
- `commit_valid` output 1: an instruction retires this cycle, including rd=x0.
- `commit_pc` output 32: PC of the retiring instruction.
- `pending` output 32: bit i is set iff a queued entry targets xi; bit 0 is always 0.
- `empty` output 1: queue empty.

## Operation
- Entry fields: `rd`, `data`, `pc`, `is_load`, `ld_type`, `ld_off`, `filled`. ALU entries are written with `filled=1`. Load entries are written with `filled=0`.
- Push: `in_valid && in_ready` writes the entry at `tail`, then `tail++` (mod DEPTH).
- Load fill: `mem_rvalid && mem_rready` fills the oldest unfilled load entry, pointed to by `ld_ptr`.
  - The stored data is `mem_rdata` after extension.
  - The entry's `filled` is set and `ld_ptr` advances to the next load entry.
  - Responses return in request order.
  - `mem_rvalid` while `mem_rready=0` is ignored.
- Extension:
  - lb/lbu: select the byte at `ld_off`.
  - lh/lhu: select the halfword at `ld_off[1]`; `ld_off[0]` is ignored.
  - lw: the full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Any other funct3: the word passes through unchanged.
- Commit: when the head entry is valid and `filled`:
  - `commit_valid=1` and `commit_pc=pc`.
  - `rf_wr_en = (rd != 0)`, with `rf_waddr=rd` and `rf_wdata=data`.
  - The head pops and `head++`.
- Commit outputs are decoded only from registered queue state, never from same-cycle inputs.
- With rd=x0: `rf_wr_en=0`, but `commit_valid=1` and the slot still consumes a commit cycle.
- `pending` is the OR over valid entries of onehot(rd), computed from registered state, with bit 0 forced to 0.
- Push and pop in the same cycle are allowed; `count` is unchanged.
- A fill and a commit of the head in the same cycle cannot target the same entry, because commit requires `filled` already registered.
- Reset, including mid-operation: `head=tail=ld_ptr=count=0` and all valid bits are cleared. In-flight load responses are discarded; upstream resets in the same cycle.

## Timing
- Reset values:
  - `in_ready=1`, `mem_rready=0`, `empty=1`.
  - `rf_wr_en=0`, `commit_valid=0`, `rf_waddr=0`, `rf_wdata=0`, `commit_pc=0`, `pending=0`.
  - `rf_waddr`/`rf_wdata`/`commit_pc` are zero whenever `commit_valid=0`.
- ALU latency: an instruction accepted in cycle N commits at the earliest in N+1.
- Load latency: a response handshaken in cycle M commits at the earliest in M+1.
- Throughput: one commit per cycle.
- `pending[rd]` rises in the cycle after the push. It falls in the cycle after the last entry with that rd commits.
- Full queue: `in_ready=0` even if a commit occurs in the same cycle; no ready bypass.

## Structure
- Shared package `ysyx_pkg` holds:
  - load funct3 constants (`LD_LB`, `LD_LH`, `LD_LW`, `LD_LBU`, `LD_LHU`);
  - the writeback entry struct typedef;
  - `XLEN=32` and `REG_AW=5`.
- Sub-module `ysyx_load_extend` is purely combinational: (`ld_type`, `ld_off`, `rdata`) → 32-bit result. It is instantiated once on the fill path.
- Queue storage, pointers, `count` and the pending decode live in `ysyx_writeback`.

## Test plan
- ALU stream: push rd=1/2/3 with data 0x11/0x22/0x33 in back-to-back cycles. Require `rf_wr_en` in the following 3 consecutive cycles with matching addr/data, in order.
- Load extend: lb with off=3 and mem_rdata=0x80FF_0000 → wdata 0xFFFF_FF80. lhu with off=2 and 0xBEEF_1234 → 0x0000_BEEF. lw → the word unchanged.
- Ordering: push a load rd=5, then an ALU op rd=6. Give the response 3 cycles later. rd=6 must not commit before rd=5; the two commit in consecutive cycles.
- Full/backpressure: fill DEPTH=4 entries with unfilled loads. Require `in_ready=0` and `pending` showing all four rds. Feed 4 responses; the queue drains in order and `empty=1` afterward.
- x0: an ALU op with rd=0 and data 0xDEAD → `commit_valid=1`, `rf_wr_en=0`, `pending[0]=0`.
- Reset mid-operation: with 3 entries queued and one load outstanding, assert `rst` for one cycle. All outputs return to reset values; a late `mem_rvalid` is ignored and causes no commit.
